// File: rtl/bus_read_y_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the Y-memory
// read block and its slot extractor.
package bus_read_y_pkg;

   localparam int Y_ROW_W    = 256;
   localparam int Y_ELEM_W   = 48;
   localparam int Y_ADDR_W   = 11;
   localparam int SLOT_PITCH = 64;
   localparam int SLOT_CNT   = 4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_DIAG  = 3'd1,
      S_RD_NDIAG = 3'd2,
      S_CAP      = 3'd3,
      S_OUT      = 3'd4
   } state_e;

   function automatic logic is_onehot(input logic [SLOT_CNT-1:0] v);
      return ($countones(v) == 1);
   endfunction

endpackage

// File: rtl/bus_read_y_slot_extract.sv
// Combinational slot picker: returns the element addressed by a one-hot
// select within a Y-memory row, or zero plus an error flag if the select is bad.
module y_slot_extract
   import bus_read_y_pkg::*;
#(
   parameter int ROW_W  = Y_ROW_W,
   parameter int ELEM_W = Y_ELEM_W
) (
   input  logic [ROW_W-1:0]    row,
   input  logic [SLOT_CNT-1:0] oh,
   output logic [ELEM_W-1:0]   elem,
   output logic                err
);

   logic [ELEM_W-1:0]   slot [SLOT_CNT];
   logic [SLOT_CNT-1:0] unused_pad;

   // Upper pad bits of each slot carry no data.
   generate
      for (genvar gi = 0; gi < SLOT_CNT; gi++) begin : g_slot
         assign slot[gi]       = row[gi*SLOT_PITCH +: ELEM_W];
         assign unused_pad[gi] = ^row[gi*SLOT_PITCH+ELEM_W +: SLOT_PITCH-ELEM_W];
      end
   endgenerate

   always_comb begin
      elem = '0;
      err  = !is_onehot(oh);
      if (!err) begin
         for (int i = 0; i < SLOT_CNT; i++) begin
            if (oh[i]) elem = slot[i];
         end
      end
   end

endmodule

// File: rtl/bus_read_y.sv
// Fetches a diagonal and a non-diagonal element from Y-memory (one or two row
// reads) and presents them as a registered pair with valid/ready handshake.
module bus_read_y
   import bus_read_y_pkg::*;
#(
   parameter int ROW_W  = Y_ROW_W,
   parameter int ELEM_W = Y_ELEM_W,
   parameter int ADDR_W = Y_ADDR_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   inDiagAddr,
   input  logic [ADDR_W-1:0]   inNonDAddr,
   input  logic [SLOT_CNT-1:0] inDiagOH,
   input  logic [SLOT_CNT-1:0] inNonDiagOH,
   output logic                op_readEn,
   output logic [ADDR_W-1:0]   op_readAddr,
   input  logic [ROW_W-1:0]    inYreadData,
   output logic [ELEM_W-1:0]   op_diagVal,
   output logic [ELEM_W-1:0]   op_nonDiagVal,
   output logic                op_valid,
   input  logic                out_ready,
   output logic                op_ohErr
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   diag_addr_q, diag_addr_d;
   logic [ADDR_W-1:0]   ndiag_addr_q, ndiag_addr_d;
   logic [SLOT_CNT-1:0] diag_oh_q, diag_oh_d;
   logic [SLOT_CNT-1:0] ndiag_oh_q, ndiag_oh_d;
   logic [ELEM_W-1:0]   diag_hold_q, diag_hold_d;
   logic                diag_err_q, diag_err_d;
   logic                req_ready_q, req_ready_d;
   logic                read_en_q, read_en_d;
   logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
   logic [ELEM_W-1:0]   diag_val_q, diag_val_d;
   logic [ELEM_W-1:0]   ndiag_val_q, ndiag_val_d;
   logic                valid_q, valid_d;
   logic                oh_err_q, oh_err_d;

   logic [ELEM_W-1:0]   diag_elem, ndiag_elem;
   logic                diag_bad, ndiag_bad;
   logic                same_row;

   y_slot_extract #(.ROW_W(ROW_W), .ELEM_W(ELEM_W)) u_diag_extract (
      .row  (inYreadData),
      .oh   (diag_oh_q),
      .elem (diag_elem),
      .err  (diag_bad)
   );

   y_slot_extract #(.ROW_W(ROW_W), .ELEM_W(ELEM_W)) u_ndiag_extract (
      .row  (inYreadData),
      .oh   (ndiag_oh_q),
      .elem (ndiag_elem),
      .err  (ndiag_bad)
   );

   assign same_row = (diag_addr_q == ndiag_addr_q);

   always_comb begin
      state_d      = state_q;
      diag_addr_d  = diag_addr_q;
      ndiag_addr_d = ndiag_addr_q;
      diag_oh_d    = diag_oh_q;
      ndiag_oh_d   = ndiag_oh_q;
      diag_hold_d  = diag_hold_q;
      diag_err_d   = diag_err_q;
      req_ready_d  = 1'b0;
      read_en_d    = 1'b0;
      read_addr_d  = read_addr_q;
      diag_val_d   = diag_val_q;
      ndiag_val_d  = ndiag_val_q;
      valid_d      = valid_q;
      oh_err_d     = oh_err_q;

      unique case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               diag_addr_d  = inDiagAddr;
               ndiag_addr_d = inNonDAddr;
               diag_oh_d    = inDiagOH;
               ndiag_oh_d   = inNonDiagOH;
               read_en_d    = 1'b1;
               read_addr_d  = inDiagAddr;
               req_ready_d  = 1'b0;
               state_d      = S_RD_DIAG;
            end
         end
         S_RD_DIAG: begin
            if (same_row) begin
               state_d = S_CAP;
            end else begin
               read_en_d   = 1'b1;
               read_addr_d = ndiag_addr_q;
               state_d     = S_RD_NDIAG;
            end
         end
         S_RD_NDIAG: begin
            // Diagonal row data is on the bus while the second read issues.
            diag_hold_d = diag_elem;
            diag_err_d  = diag_bad;
            state_d     = S_CAP;
         end
         S_CAP: begin
            ndiag_val_d = ndiag_elem;
            if (same_row) begin
               diag_val_d = diag_elem;
               oh_err_d   = diag_bad | ndiag_bad;
            end else begin
               diag_val_d = diag_hold_q;
               oh_err_d   = diag_err_q | ndiag_bad;
            end
            valid_d = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               valid_d     = 1'b0;
               oh_err_d    = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         diag_addr_q  <= '0;
         ndiag_addr_q <= '0;
         diag_oh_q    <= '0;
         ndiag_oh_q   <= '0;
         diag_hold_q  <= '0;
         diag_err_q   <= 1'b0;
         req_ready_q  <= 1'b0;
         read_en_q    <= 1'b0;
         read_addr_q  <= '0;
         diag_val_q   <= '0;
         ndiag_val_q  <= '0;
         valid_q      <= 1'b0;
         oh_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         diag_addr_q  <= diag_addr_d;
         ndiag_addr_q <= ndiag_addr_d;
         diag_oh_q    <= diag_oh_d;
         ndiag_oh_q   <= ndiag_oh_d;
         diag_hold_q  <= diag_hold_d;
         diag_err_q   <= diag_err_d;
         req_ready_q  <= req_ready_d;
         read_en_q    <= read_en_d;
         read_addr_q  <= read_addr_d;
         diag_val_q   <= diag_val_d;
         ndiag_val_q  <= ndiag_val_d;
         valid_q      <= valid_d;
         oh_err_q     <= oh_err_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign op_readEn     = read_en_q;
   assign op_readAddr   = read_addr_q;
   assign op_diagVal    = diag_val_q;
   assign op_nonDiagVal = ndiag_val_q;
   assign op_valid      = valid_q;
   assign op_ohErr      = oh_err_q;

endmodule

// File: tb/tb_bus_read_y.sv
// Directed bench for bus_read_y: behavioural Y-memory, read-address logger and
// hand-computed expectations for each request scenario.
module tb_bus_read_y;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [10:0]   inDiagAddr = '0;
   logic [10:0]   inNonDAddr = '0;
   logic [3:0]    inDiagOH = '0;
   logic [3:0]    inNonDiagOH = '0;
   logic          op_readEn;
   logic [10:0]   op_readAddr;
   logic [255:0]  inYreadData = '0;
   logic [47:0]   op_diagVal;
   logic [47:0]   op_nonDiagVal;
   logic          op_valid;
   logic          out_ready = 1'b0;
   logic          op_ohErr;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [255:0]  ymem [16];
   logic [10:0]   rd_q [$];

   bus_read_y dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .inDiagAddr    (inDiagAddr),
      .inNonDAddr    (inNonDAddr),
      .inDiagOH      (inDiagOH),
      .inNonDiagOH   (inNonDiagOH),
      .op_readEn     (op_readEn),
      .op_readAddr   (op_readAddr),
      .inYreadData   (inYreadData),
      .op_diagVal    (op_diagVal),
      .op_nonDiagVal (op_nonDiagVal),
      .op_valid      (op_valid),
      .out_ready     (out_ready),
      .op_ohErr      (op_ohErr)
   );

   always #5 clock = ~clock;

   // Y-memory returns the row one cycle after the strobe; every strobe is logged.
   always @(posedge clock) begin
      if (op_readEn) begin
         inYreadData <= ymem[op_readAddr[3:0]];
         rd_q.push_back(op_readAddr);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!op_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_req(input string name,
                          input logic [10:0] da, input logic [10:0] na,
                          input logic [3:0] doh, input logic [3:0] noh,
                          input int exp_lat, input logic [47:0] ed,
                          input logic [47:0] en, input logic exp_err,
                          input int stall);
      int n;
      int lat;
      int nrd;
      inDiagAddr  = da;
      inNonDAddr  = na;
      inDiagOH    = doh;
      inNonDiagOH = noh;
      req_valid   = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      check({name, "_ready"}, 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      rd_q.delete();
      wait_valid(lat);
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_diag"}, 64'(op_diagVal), 64'(ed));
      check({name, "_ndiag"}, 64'(op_nonDiagVal), 64'(en));
      check({name, "_oherr"}, 64'(op_ohErr), 64'(exp_err));
      nrd = (da == na) ? 1 : 2;
      check({name, "_nreads"}, 64'(rd_q.size()), 64'(nrd));
      if (rd_q.size() >= 1) check({name, "_rd0"}, 64'(rd_q[0]), 64'(da));
      if (rd_q.size() >= 2) check({name, "_rd1"}, 64'(rd_q[1]), 64'(na));
      for (int i = 0; i < stall; i++) begin
         if (i == 0) begin
            inDiagAddr  = 11'd12;
            inNonDAddr  = 11'd13;
            req_valid   = 1'b1;
         end
         tick();
         check({name, "_stall_valid"}, 64'(op_valid), 64'd1);
         check({name, "_stall_diag"}, 64'(op_diagVal), 64'(ed));
         check({name, "_stall_ndiag"}, 64'(op_nonDiagVal), 64'(en));
         check({name, "_stall_ready"}, 64'(req_ready), 64'd0);
      end
      if (stall > 0) begin
         req_valid = 1'b0;
         check({name, "_stall_reads"}, 64'(rd_q.size()), 64'(nrd));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_done_valid"}, 64'(op_valid), 64'd0);
      check({name, "_done_oherr"}, 64'(op_ohErr), 64'd0);
      check({name, "_done_ready"}, 64'(req_ready), 64'd1);
      $display("txn %s: diag=%0h ndiag=%0h err=%0b lat=%0d", name, ed, en, exp_err, exp_lat);
   endtask

   initial begin
      int lat;
      int seen;
      // Default row r slot s: pad FACE, real 0x100000+16r+s, img 0x200000+16r+s.
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < 4; s++) begin
            ymem[r][s*64 +: 64] = {16'hFACE, 24'(24'h100000 + r*16 + s), 24'(24'h200000 + r*16 + s)};
         end
      end
      ymem[5][0 +: 64]   = {16'hDEAD, 48'h000123_000456};
      ymem[9][128 +: 64] = {16'hBEEF, 48'hABCDEF_012345};
      ymem[7][192 +: 64] = {16'h1234, 48'h777333_333777};
      ymem[7][64 +: 64]  = {16'h5678, 48'h111777_777111};

      // Reset state
      #2;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rden", 64'(op_readEn), 64'd0);
      check("rst_rdaddr", 64'(op_readAddr), 64'd0);
      check("rst_diag", 64'(op_diagVal), 64'd0);
      check("rst_ndiag", 64'(op_nonDiagVal), 64'd0);
      check("rst_valid", 64'(op_valid), 64'd0);
      check("rst_oherr", 64'(op_ohErr), 64'd0);
      tick();
      tick();
      @(negedge clock);
      reset = 1'b1;
      tick();
      check("rel_ready", 64'(req_ready), 64'd1);
      $display("txn reset: released");

      run_req("two_reads", 11'd5, 11'd9, 4'b0001, 4'b0100, 4,
              48'h000123_000456, 48'hABCDEF_012345, 1'b0, 0);
      run_req("one_read", 11'd7, 11'd7, 4'b1000, 4'b0010, 3,
              48'h777333_333777, 48'h111777_777111, 1'b0, 0);
      run_req("diag_multi_oh", 11'd3, 11'd2, 4'b0110, 4'b1000, 4,
              48'h0, 48'h100023_200023, 1'b1, 0);
      run_req("ndiag_zero_oh", 11'd4, 11'd4, 4'b0010, 4'b0000, 3,
              48'h100041_200041, 48'h0, 1'b1, 0);
      run_req("stall", 11'd9, 11'd5, 4'b0100, 4'b0001, 4,
              48'hABCDEF_012345, 48'h000123_000456, 1'b0, 5);

      // Reset pulsed while the second read is on the bus
      inDiagAddr  = 11'd5;
      inNonDAddr  = 11'd9;
      inDiagOH    = 4'b0001;
      inNonDiagOH = 4'b0100;
      req_valid   = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      check("mid_rst_rdndiag_en", 64'(op_readEn), 64'd1);
      check("mid_rst_rdndiag_addr", 64'(op_readAddr), 64'd9);
      reset = 1'b0;
      #1;
      check("mid_rst_rden", 64'(op_readEn), 64'd0);
      check("mid_rst_ready", 64'(req_ready), 64'd0);
      check("mid_rst_valid", 64'(op_valid), 64'd0);
      tick();
      @(negedge clock);
      reset = 1'b1;
      tick();
      check("mid_rst_rel_ready", 64'(req_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (op_valid) seen++;
         tick();
      end
      check("mid_rst_no_valid", 64'(seen), 64'd0);
      $display("txn mid_reset: abandoned request, valid_seen=%0d", seen);
      run_req("after_rst", 11'd9, 11'd5, 4'b0100, 4'b0001, 4,
              48'hABCDEF_012345, 48'h000123_000456, 1'b0, 0);

      // Back-to-back with req_valid held high and consumer always ready
      rd_q.delete();
      out_ready   = 1'b1;
      inDiagAddr  = 11'd1;
      inNonDAddr  = 11'd2;
      inDiagOH    = 4'b0001;
      inNonDiagOH = 4'b0010;
      req_valid   = 1'b1;
      wait_valid(lat);
      check("b2b_first_diag", 64'(op_diagVal), 64'h100010_200010);
      check("b2b_first_ndiag", 64'(op_nonDiagVal), 64'h100021_200021);
      inDiagAddr  = 11'd6;
      inNonDAddr  = 11'd6;
      inDiagOH    = 4'b0100;
      inNonDiagOH = 4'b1000;
      tick();
      check("b2b_idle_valid", 64'(op_valid), 64'd0);
      check("b2b_idle_ready", 64'(req_ready), 64'd1);
      tick();
      check("b2b_second_rden", 64'(op_readEn), 64'd1);
      check("b2b_second_addr", 64'(op_readAddr), 64'd6);
      check("b2b_second_ready", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      wait_valid(lat);
      check("b2b_second_lat", 64'(lat), 64'd3);
      check("b2b_second_diag", 64'(op_diagVal), 64'h100062_200062);
      check("b2b_second_ndiag", 64'(op_nonDiagVal), 64'h100063_200063);
      check("b2b_nreads", 64'(rd_q.size()), 64'd3);
      if (rd_q.size() == 3) begin
         check("b2b_rd0", 64'(rd_q[0]), 64'd1);
         check("b2b_rd1", 64'(rd_q[1]), 64'd2);
         check("b2b_rd2", 64'(rd_q[2]), 64'd6);
      end
      tick();
      out_ready = 1'b0;
      check("b2b_done_valid", 64'(op_valid), 64'd0);
      $display("txn back_to_back: reads=%0d", rd_q.size());

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

endmodule
